// File: rtl/priority_code_decoder_16bit_pkg.sv
// Shared constants, FSM state type and code-legality helper for the
// priority code decoder.
package priority_pkg;

   localparam int unsigned        MASK_W    = 16;
   localparam int unsigned        CODE_W    = 8;
   localparam int unsigned        CNT_W     = 5;
   localparam logic [CODE_W-1:0]  NONE_CODE = 8'hF0;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   // A code is legal when it indexes a mask bit or is the "no bit set" code.
   function automatic logic is_legal_code(
      input int unsigned code,
      input int unsigned mask_w    = MASK_W,
      input int unsigned none_code = int'(NONE_CODE)
   );
      return (code < mask_w) || (code == none_code);
   endfunction

endpackage

// File: rtl/priority_code_decoder_16bit_onehot_decode.sv
// Combinational index-code to one-hot decoder with a legality flag.
// NONE_CODE is legal and decodes to an all-zero mask.
module onehot_decode #(
   parameter int unsigned                   MASK_W    = priority_pkg::MASK_W,
   parameter int unsigned                   CODE_W    = priority_pkg::CODE_W,
   parameter logic [CODE_W-1:0]             NONE_CODE = priority_pkg::NONE_CODE
) (
   input  logic [CODE_W-1:0] code,
   output logic [MASK_W-1:0] onehot,
   output logic              legal
);
   import priority_pkg::*;

   localparam int unsigned       IDX_W = $clog2(MASK_W);
   localparam logic [MASK_W-1:0] ONE   = MASK_W'(1);

   logic in_range;

   always_comb begin
      in_range = (int'(code) < int'(MASK_W));
      legal    = is_legal_code(int'(code), MASK_W, int'(NONE_CODE));
      onehot   = '0;
      if (in_range) begin
         onehot = ONE << code[IDX_W-1:0];
      end
   end

endmodule

// File: rtl/priority_code_decoder_16bit.sv
// Rebuilds a one-hot mask from priority-encoder index codes, either one code
// per mask (single-shot) or OR-ing a stream of codes until commit (accumulate).
module priority_code_decoder_16bit #(
   parameter int unsigned       MASK_W    = priority_pkg::MASK_W,
   parameter int unsigned       CODE_W    = priority_pkg::CODE_W,
   parameter logic [CODE_W-1:0] NONE_CODE = priority_pkg::NONE_CODE,
   parameter int unsigned       CNT_W     = priority_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CODE_W-1:0] code_in,
   input  logic              code_valid,
   input  logic              accum_en,
   input  logic              commit,
   input  logic              clear,
   output logic [MASK_W-1:0] mask_out,
   output logic              mask_valid,
   output logic              code_err,
   output logic              busy,
   output logic [CNT_W-1:0]  code_count
);
   import priority_pkg::*;

   state_t            state, state_next;
   logic [MASK_W-1:0] acc, acc_next;
   logic [MASK_W-1:0] mask_next;
   logic              mask_valid_next;
   logic              code_err_next;
   logic [CNT_W-1:0]  count_next;
   logic [CNT_W-1:0]  count_inc;

   logic [MASK_W-1:0] onehot;
   logic              legal;
   logic              take;

   onehot_decode #(
      .MASK_W    (MASK_W),
      .CODE_W    (CODE_W),
      .NONE_CODE (NONE_CODE)
   ) u_decode (
      .code   (code_in),
      .onehot (onehot),
      .legal  (legal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         acc        <= '0;
         mask_out   <= '0;
         mask_valid <= 1'b0;
         code_err   <= 1'b0;
         code_count <= '0;
      end else begin
         state      <= state_next;
         acc        <= acc_next;
         mask_out   <= mask_next;
         mask_valid <= mask_valid_next;
         code_err   <= code_err_next;
         code_count <= count_next;
      end
   end

   always_comb begin
      take            = code_valid && legal;
      count_inc       = (code_count == '1) ? code_count : code_count + CNT_W'(1);
      state_next      = state;
      acc_next        = acc;
      mask_next       = mask_out;
      mask_valid_next = 1'b0;
      code_err_next   = code_err || (code_valid && !legal);
      count_next      = code_count;

      if (clear) begin
         state_next    = IDLE;
         acc_next      = '0;
         mask_next     = '0;
         code_err_next = 1'b0;
         count_next    = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (take) begin
                  count_next = CNT_W'(1);
                  if (accum_en) begin
                     acc_next   = onehot;
                     state_next = ACCUM;
                  end else begin
                     mask_next       = onehot;
                     mask_valid_next = 1'b1;
                  end
               end
            end
            ACCUM: begin
               // A legal code arriving with commit still belongs to this frame.
               if (commit) begin
                  mask_next       = take ? (acc | onehot) : acc;
                  count_next      = take ? count_inc : code_count;
                  mask_valid_next = 1'b1;
                  acc_next        = '0;
                  state_next      = IDLE;
               end else if (take) begin
                  acc_next   = acc | onehot;
                  count_next = count_inc;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign busy = (state == ACCUM);

endmodule

// File: tb/tb_priority_code_decoder_16bit.sv
// Randomized and directed bench for priority_code_decoder_16bit against a
// behavioural frame model.
module tb_priority_code_decoder_16bit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  code_in;
   logic        code_valid, accum_en, commit, clear;
   logic [15:0] mask_out;
   logic        mask_valid, code_err, busy;
   logic [4:0]  code_count;

   int total = 0;
   int bad   = 0;

   priority_code_decoder_16bit #(
      .MASK_W    (16),
      .CODE_W    (8),
      .NONE_CODE (8'hF0),
      .CNT_W     (5)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .code_in    (code_in),
      .code_valid (code_valid),
      .accum_en   (accum_en),
      .commit     (commit),
      .clear      (clear),
      .mask_out   (mask_out),
      .mask_valid (mask_valid),
      .code_err   (code_err),
      .busy       (busy),
      .code_count (code_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit in_frame;
      int acc;
      int mask;
      int cnt;
      bit mv;
      bit err;
   } model_t;

   model_t m = '{default: 0};

   function automatic model_t model_step(model_t cur, bit v, int code, bit ae, bit cm, bit cl);
      model_t n;
      bit     ok;
      int     bits;
      n    = cur;
      ok   = (code < 16) || (code == 'hF0);
      bits = (code < 16) ? (1 << code) : 0;
      if (cl) return '{default: 0};
      n.mv = 0;
      if (v && !ok) n.err = 1;
      if (cur.in_frame && cm) begin
         if (v && ok) begin
            n.mask = cur.acc | bits;
            n.cnt  = (cur.cnt + 1 > 31) ? 31 : cur.cnt + 1;
         end else begin
            n.mask = cur.acc;
         end
         n.mv       = 1;
         n.in_frame = 0;
         n.acc      = 0;
      end else if (v && ok) begin
         if (cur.in_frame) begin
            n.acc = cur.acc | bits;
            n.cnt = (cur.cnt + 1 > 31) ? 31 : cur.cnt + 1;
         end else if (ae) begin
            n.in_frame = 1;
            n.acc      = bits;
            n.cnt      = 1;
         end else begin
            n.mask = bits;
            n.mv   = 1;
            n.cnt  = 1;
         end
      end
      return n;
   endfunction

   function automatic int encode16(int mask);
      for (int i = 15; i >= 0; i--) if (mask[i]) return i;
      return 'hF0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '{default: 0};
      else        m <= model_step(m, code_valid, int'(code_in), accum_en, commit, clear);
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("model.mask_out",   int'(mask_out),   m.mask);
      check("model.mask_valid", int'(mask_valid), int'(m.mv));
      check("model.code_err",   int'(code_err),   int'(m.err));
      check("model.busy",       int'(busy),       int'(m.in_frame));
      check("model.code_count", int'(code_count), m.cnt);
   end

   task automatic cyc(input bit v, input int code, input bit ae, input bit cm, input bit cl);
      code_valid = v;
      code_in    = 8'(code);
      accum_en   = ae;
      commit     = cm;
      clear      = cl;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      code_in = '0; code_valid = 0; accum_en = 0; commit = 0; clear = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check("reset.mask_out", int'(mask_out), 0);
      check("reset.flags", int'({mask_valid, code_err, busy}), 0);
      check("reset.code_count", int'(code_count), 0);

      cyc(1, 5, 0, 0, 0);
      check("ss5.mask_out", int'(mask_out), 'h0020);
      check("ss5.mask_valid", int'(mask_valid), 1);
      check("ss5.code_count", int'(code_count), 1);
      check("ss5.busy", int'(busy), 0);
      idle();
      check("ss5.pulse_end", int'(mask_valid), 0);
      check("ss5.hold", int'(mask_out), 'h0020);

      cyc(1, 'hF0, 0, 0, 0);
      check("none.mask_out", int'(mask_out), 0);
      check("none.mask_valid", int'(mask_valid), 1);
      check("none.code_err", int'(code_err), 0);
      cyc(1, 'h3C, 0, 0, 0);
      check("illegal.mask_valid", int'(mask_valid), 0);
      check("illegal.code_err", int'(code_err), 1);
      idle();
      check("illegal.sticky", int'(code_err), 1);

      cyc(1, 3, 1, 0, 0);
      check("acc.busy", int'(busy), 1);
      check("acc.no_pulse", int'(mask_valid), 0);
      cyc(1, 15, 0, 0, 0);
      cyc(1, 3, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      check("acc.mask_out", int'(mask_out), 'h8008);
      check("acc.code_count", int'(code_count), 3);
      check("acc.mask_valid", int'(mask_valid), 1);
      check("acc.busy_end", int'(busy), 0);

      cyc(1, 8, 1, 0, 0);
      cyc(1, 0, 0, 1, 0);
      check("commit_code.mask_out", int'(mask_out), 'h0101);
      check("commit_code.code_count", int'(code_count), 2);

      cyc(1, 2, 1, 0, 0);
      cyc(1, 4, 0, 0, 0);
      cyc(1, 6, 0, 1, 1);
      check("clear.mask_out", int'(mask_out), 0);
      check("clear.flags", int'({mask_valid, code_err, busy}), 0);
      check("clear.code_count", int'(code_count), 0);

      cyc(1, 9, 0, 0, 0);
      cyc(1, 2, 1, 0, 0);
      cyc(1, 7, 0, 0, 0);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst.mask_out", int'(mask_out), 0);
      check("async_rst.busy", int'(busy), 0);
      check("async_rst.code_count", int'(code_count), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int c = 0; c < 16; c++) begin
         cyc(1, c, 0, 0, 0);
         check("sweep.roundtrip", encode16(int'(mask_out)), c);
      end
      cyc(1, 'hF0, 0, 0, 0);
      check("sweep.none_roundtrip", encode16(int'(mask_out)), 'hF0);

      cyc(1, int'($urandom_range(0, 15)), 1, 0, 0);
      for (int i = 1; i < 32; i++) cyc(1, int'($urandom_range(0, 15)), 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      check("sat.code_count", int'(code_count), 31);

      for (int i = 0; i < 3000; i++) begin
         int r, code;
         r = int'($urandom_range(0, 99));
         if (r < 70)      code = int'($urandom_range(0, 15));
         else if (r < 80) code = 'hF0;
         else             code = int'($urandom_range(0, 255));
         cyc(($urandom_range(0, 3) != 0), code, $urandom_range(0, 1) == 1,
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 39) == 0));
      end

      idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
